// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, opcode encodings, the last legal
// opcode and the instruction-fetch state encoding.
package cpu_pkg;

    localparam int XLEN = 16;

    // R-type group
    localparam logic [3:0] OP_R0  = 4'b0000;
    localparam logic [3:0] OP_R1  = 4'b0001;
    localparam logic [3:0] OP_R2  = 4'b0010;
    localparam logic [3:0] OP_R3  = 4'b0011;
    localparam logic [3:0] OP_ORI = 4'b0100;
    localparam logic [3:0] OP_R5  = 4'b0101;
    localparam logic [3:0] OP_R6  = 4'b0110;
    localparam logic [3:0] OP_SW  = 4'b0111;
    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_BLT = 4'b1001;

    // Everything above this encoding is reserved and stops fetch.
    localparam logic [3:0] OP_LAST_LEGAL = 4'b1001;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_VALID = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

    function automatic logic is_illegal_op(input logic [3:0] op);
        return op > OP_LAST_LEGAL;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with load and increment.
// Ports:
//   clk, rst_n   clock, async active-low reset (PC <= RESET_PC)
//   load_i       load load_val_i (takes priority over increment)
//   load_val_i   value to load
//   inc_i        PC <= PC + 1, wrapping at 2^XLEN
//   pc_o         current PC
//   pc_d_o       value the PC takes at the next edge
module pc_reg #(
    parameter int              XLEN     = 16,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic [XLEN-1:0] load_val_i,
    input  logic            inc_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_d_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o   = pc_q;
    assign pc_d_o = pc_d;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory read at a time, hands the
// fetched word to decode with a valid/ready handshake, follows branch
// redirects and stops permanently on a reserved opcode.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_FETCH | request outstanding (or about to issue) at the current PC
// ST_VALID | instruction held for decode until handshake or redirect
// ST_HALT  | reserved opcode accepted; fetch stopped until reset
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   imem_req/imem_addr         read request and word address (held until ack)
//   imem_ack/imem_rdata        read response, any latency >= 1
//   instr_valid/decode_ready   handshake to decode
//   instr/opcode/instr_pc      instruction word, its top nibble, its address
//   redirect/redirect_pc       taken branch from execute
//   illegal                    held instruction has a reserved opcode
//   halted                     fetch stopped
module instr_fetch #(
    parameter int              XLEN     = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            decode_ready,
    output logic [XLEN-1:0] instr,
    output logic [3:0]      opcode,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            illegal,
    output logic            halted
);

    import cpu_pkg::*;

    fetch_state_t    state_q;
    logic            stale_q;
    logic            req_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] instr_pc_q;
    logic            valid_q;
    logic            illegal_q;
    logic            halted_q;

    logic            pc_load;
    logic            pc_inc;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            handshake;

    assign handshake = valid_q & decode_ready;

    always_comb begin
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        unique case (state_q)
            ST_FETCH: pc_load = redirect;
            ST_VALID: begin
                pc_load = redirect;
                pc_inc  = !redirect && handshake && !illegal_q;
            end
            default: ;
        endcase
    end

    pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (pc_load),
        .load_val_i (redirect_pc),
        .inc_i      (pc_inc),
        .pc_o       (pc_q),
        .pc_d_o     (pc_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            stale_q    <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            illegal_q  <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    if (!req_q) begin
                        // First cycle after reset: any ack now belongs to
                        // a request abandoned by reset and is ignored.
                        req_q  <= 1'b1;
                        addr_q <= pc_d;
                    end else if (imem_ack) begin
                        if (stale_q || redirect) begin
                            // Drop the data and refetch at the newest target.
                            stale_q <= 1'b0;
                            addr_q  <= pc_d;
                        end else begin
                            req_q      <= 1'b0;
                            instr_q    <= imem_rdata;
                            instr_pc_q <= addr_q;
                            valid_q    <= 1'b1;
                            illegal_q  <= is_illegal_op(imem_rdata[XLEN-1 -: 4]);
                            state_q    <= ST_VALID;
                        end
                    end else if (redirect) begin
                        stale_q <= 1'b1;
                    end
                end
                ST_VALID: begin
                    if (redirect) begin
                        valid_q   <= 1'b0;
                        illegal_q <= 1'b0;
                        req_q     <= 1'b1;
                        addr_q    <= pc_d;
                        state_q   <= ST_FETCH;
                    end else if (handshake) begin
                        valid_q   <= 1'b0;
                        illegal_q <= 1'b0;
                        if (illegal_q) begin
                            halted_q <= 1'b1;
                            state_q  <= ST_HALT;
                        end else begin
                            req_q   <= 1'b1;
                            addr_q  <= pc_d;
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_HALT: ;
                default: state_q <= ST_HALT;
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[XLEN-1 -: 4];
    assign instr_pc    = instr_pc_q;
    assign illegal     = illegal_q;
    assign halted      = halted_q;

endmodule
